// File: rtl/offnariscv_pkg.sv
// Shared types and constants for the offnariscv front end.
package offnariscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PCGEN_RESET_VECTOR = 32'h8000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pcgen_state_e;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream channel: source drives tdata/tvalid, sink drives tready.
interface axis_if #(
  parameter int W = 32
);
  // A beat transfers on a rising edge where tvalid and tready are both high;
  // once raised, tvalid holds with stable tdata until the transfer.
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport source (output tdata, output tvalid, input tready);
  modport sink   (input tdata, input tvalid, output tready);
endinterface

// File: rtl/pcgen_core.sv
// Fetch-address sequencer: issues PCs, tracks returns, flushes on redirect.
module pcgen_core
  import offnariscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = PCGEN_RESET_VECTOR,
  parameter int              MAX_INFLIGHT = 2
) (
  input  logic            clk,
  input  logic            rst,
  axis_if.source          next_pc_axis_if,
  axis_if.sink            current_pc_axis_if,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            invalidate
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  pcgen_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            invalidate_d;
  logic [CW-1:0]   inflight;
  logic            below_max, inflight_empty;
  logic            issue, ret;

  assign next_pc_axis_if.tvalid   = (state_q == RUN) && below_max;
  assign next_pc_axis_if.tdata    = pc_q;
  assign current_pc_axis_if.tready = (state_q != BOOT);

  assign issue = next_pc_axis_if.tvalid && next_pc_axis_if.tready;
  assign ret   = current_pc_axis_if.tvalid && current_pc_axis_if.tready;

  pcgen_inflight_ctr #(.MAX(MAX_INFLIGHT), .W(CW)) u_inflight (
    .clk       (clk),
    .rst       (rst),
    .inc       (issue),
    .dec       (ret),
    .count     (inflight),
    .below_max (below_max),
    .empty     (inflight_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      invalidate <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      invalidate <= invalidate_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    invalidate_d = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, FLUSH: begin
        // Redirect wins over sequential advance; a beat issued alongside it is stale.
        if (redirect_valid) begin
          pc_d         = {redirect_pc[XLEN-1:2], 2'b00};
          invalidate_d = 1'b1;
          state_d      = FLUSH;
        end else if (state_q == RUN) begin
          if (issue) pc_d = pc_q + XLEN'(4);
        end else if (inflight_empty) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // In RUN every outstanding beat is sequential, so the oldest is pc - 4*inflight.
  always @(posedge clk) begin
    if (rst && state_q == RUN && ret) begin
      assert (current_pc_axis_if.tdata == pc_q - (XLEN'(inflight) << 2));
    end
  end

endmodule

// File: rtl/pcgen_inflight_ctr.sv
// Saturating up/down counter of fetches in flight, with a compare against the limit.
module pcgen_inflight_ctr #(
  parameter int MAX = 2,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         below_max,
  output logic         empty
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + W'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign below_max = (count < W'(MAX));
  assign empty     = (count == '0);

  // A return with nothing outstanding means the IFU broke the protocol.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(dec && !inc && count == '0));
    end
  end

endmodule

// File: rtl/pcgen.sv
// Program counter generator top: flat AXI-Stream ports bound onto axis_if channels.
module pcgen
  import offnariscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = PCGEN_RESET_VECTOR,
  parameter int              MAX_INFLIGHT = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] next_pc_tdata,
  output logic            next_pc_tvalid,
  input  logic            next_pc_tready,
  input  logic [XLEN-1:0] current_pc_tdata,
  input  logic            current_pc_tvalid,
  output logic            current_pc_tready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            invalidate
);

  axis_if #(.W(XLEN)) next_pc_axis_if ();
  axis_if #(.W(XLEN)) current_pc_axis_if ();

  assign next_pc_tdata             = next_pc_axis_if.tdata;
  assign next_pc_tvalid            = next_pc_axis_if.tvalid;
  assign next_pc_axis_if.tready    = next_pc_tready;
  assign current_pc_axis_if.tdata  = current_pc_tdata;
  assign current_pc_axis_if.tvalid = current_pc_tvalid;
  assign current_pc_tready         = current_pc_axis_if.tready;

  pcgen_core #(.RESET_VECTOR(RESET_VECTOR), .MAX_INFLIGHT(MAX_INFLIGHT)) u_core (
    .clk                (clk),
    .rst                (rst),
    .next_pc_axis_if    (next_pc_axis_if),
    .current_pc_axis_if (current_pc_axis_if),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .invalidate         (invalidate)
  );

endmodule

// File: tb/tb_pcgen.sv
// Directed and randomized bench for pcgen against a queue-based fetch model.
module tb_pcgen;

  localparam int          MAX = 2;
  localparam logic [31:0] RV  = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] next_pc_tdata;
  logic        next_pc_tvalid;
  logic        next_pc_tready;
  logic [31:0] current_pc_tdata;
  logic        current_pc_tvalid;
  logic        current_pc_tready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        invalidate;

  int checks = 0;
  int errors = 0;

  // Model: m_mode 0=boot 1=running 2=draining; exp_q holds PCs accepted but not returned.
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_inv;
  logic [31:0] exp_q[$];

  pcgen dut (
    .clk               (clk),
    .rst               (rst),
    .next_pc_tdata     (next_pc_tdata),
    .next_pc_tvalid    (next_pc_tvalid),
    .next_pc_tready    (next_pc_tready),
    .current_pc_tdata  (current_pc_tdata),
    .current_pc_tvalid (current_pc_tvalid),
    .current_pc_tready (current_pc_tready),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .invalidate        (invalidate)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0b want %0b", tag, got, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %08h want %08h", tag, got, exp);
    end
  endtask

  // Driver: returns always carry the oldest outstanding PC and are never offered when none is out.
  task automatic drive(input bit tr, input bit cv, input bit rv, input logic [31:0] rp);
    next_pc_tready    = tr;
    current_pc_tvalid = cv && (exp_q.size() > 0);
    current_pc_tdata  = (exp_q.size() > 0) ? exp_q[0] : $urandom();
    redirect_valid    = rv;
    redirect_pc       = rp;
  endtask

  // Scoreboard step: compare outputs, clock once, advance the model.
  task automatic tick();
    bit exp_valid;
    bit issued;
    int n;
    exp_valid = (m_mode == 1) && (exp_q.size() < MAX);
    n = exp_q.size();
    check1("next_pc_tvalid", next_pc_tvalid, exp_valid);
    check32("next_pc_tdata", next_pc_tdata, m_pc);
    check1("current_pc_tready", current_pc_tready, m_mode != 0);
    check1("invalidate", invalidate, m_inv);
    issued = exp_valid && next_pc_tready;
    @(posedge clk);
    if (!rst) begin
      m_mode = 0;
      m_pc   = RV;
      m_inv  = 1'b0;
      exp_q.delete();
    end else begin
      if (current_pc_tvalid && m_mode != 0 && n > 0) void'(exp_q.pop_front());
      if (issued) exp_q.push_back(m_pc);
      m_inv = 1'b0;
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (redirect_valid) begin
        m_pc   = redirect_pc & ~32'h3;
        m_inv  = 1'b1;
        m_mode = 2;
      end else if (m_mode == 1) begin
        if (issued) m_pc = m_pc + 32'd4;
      end else if (n == 0) begin
        m_mode = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    check1("boot_tvalid", next_pc_tvalid, 1'b0);
    tick();
  endtask

  initial begin
    bit          tr, cv, rv;
    logic [31:0] rp;
    rst = 1'b0;
    drive(0, 0, 0, 32'h0);
    m_mode = 0;
    m_pc   = RV;
    m_inv  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("reset_tdata", next_pc_tdata, RV);
    check1("reset_tvalid", next_pc_tvalid, 1'b0);
    check1("reset_cur_ready", current_pc_tready, 1'b0);

    // Streaming with one-cycle echo
    do_reset();
    check1("first_valid", next_pc_tvalid, 1'b1);
    check32("first_pc", next_pc_tdata, RV);
    repeat (8) begin
      drive(1, 1, 0, 32'h0);
      tick();
    end

    // Stall at MAX_INFLIGHT, then resume after one return
    do_reset();
    repeat (4) begin
      drive(1, 0, 0, 32'h0);
      tick();
    end
    check1("stall_at_max", next_pc_tvalid, 1'b0);
    drive(1, 1, 0, 32'h0);
    tick();
    drive(1, 0, 0, 32'h0);
    check1("resume_valid", next_pc_tvalid, 1'b1);
    check32("resume_pc", next_pc_tdata, 32'h8000_0008);
    tick();

    // Redirect with two outstanding, drain, then resume at aligned target
    drive(1, 0, 1, 32'h8000_1003);
    tick();
    check1("redir_inv", invalidate, 1'b1);
    drive(1, 0, 0, 32'h0);
    tick();
    check1("redir_inv_once", invalidate, 1'b0);
    drive(1, 1, 0, 32'h0);
    tick();
    tick();
    drive(1, 0, 0, 32'h0);
    check1("drain_no_issue", next_pc_tvalid, 1'b0);
    tick();
    check32("redir_target", next_pc_tdata, 32'h8000_1000);
    tick();
    check32("redir_next", next_pc_tdata, 32'h8000_1004);
    tick();

    // Hold while not ready
    do_reset();
    repeat (5) begin
      drive(0, 0, 0, 32'h0);
      tick();
    end
    check32("hold_pc", next_pc_tdata, RV);

    // Consecutive redirects
    drive(0, 0, 1, 32'h100);
    tick();
    check1("dbl_inv1", invalidate, 1'b1);
    drive(0, 0, 1, 32'h200);
    tick();
    check1("dbl_inv2", invalidate, 1'b1);
    drive(1, 0, 0, 32'h0);
    tick();
    check32("dbl_target", next_pc_tdata, 32'h200);

    // Wrap at top of address space, then reset mid-flush
    drive(0, 0, 1, 32'hFFFF_FFFC);
    tick();
    drive(1, 0, 0, 32'h0);
    tick();
    check32("wrap_first", next_pc_tdata, 32'hFFFF_FFFC);
    tick();
    check32("wrap_zero", next_pc_tdata, 32'h0);
    tick();
    drive(0, 0, 1, 32'h1234);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 32'h0);
    tick();
    check1("flush_rst_ready", current_pc_tready, 1'b0);
    rst = 1'b1;
    tick();
    check32("post_rst_pc", next_pc_tdata, RV);

    // Randomized traffic
    repeat (2000) begin
      rst = ($urandom_range(0, 199) != 0);
      tr  = ($urandom_range(0, 3) != 0);
      cv  = ($urandom_range(0, 1) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      drive(tr, cv, rv, rp);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcgen.md
# pcgen

Program counter generator: the fetch stage directly upstream of the IFU. It produces the stream of fetch addresses on the next-PC AXI-Stream channel and counts fetches in flight using the IFU's current-PC feedback channel. On a control-flow redirect from the back end it pulses `invalidate` to flush the IFU and drains stale in-flight fetches before it resumes at the new target.

## Interface

- `RESET_VECTOR`, default `32'h8000_0000`: first fetch address after reset.
- `MAX_INFLIGHT`, default 2: maximum number of next-PC beats accepted by the IFU but not yet returned on current-PC.
- `XLEN`, from `offnariscv_pkg`.

Ports:

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `next_pc_tdata`  out  XLEN  fetch address to the IFU; carried in `axis_if` `next_pc_axis_if`, source side.
- `next_pc_tvalid`  out  1  fetch address valid.
- `next_pc_tready`  in  1  IFU accepts the fetch address.
- `current_pc_tdata`  in  XLEN  PC of a fetch the IFU has completed; carried in `current_pc_axis_if`, sink side.
- `current_pc_tvalid`  in  1  current-PC beat valid.
- `current_pc_tready`  out  1  pcgen accepts the current-PC beat.
- `redirect_valid`  in  1  back-end redirect (branch mispredict, trap, fence.i); no ready, always accepted.
- `redirect_pc`  in  XLEN  redirect target.
- `invalidate`  out  1  one-cycle flush pulse to the IFU and the decoder path.

## Operation

- State machine with three states: BOOT, RUN, FLUSH.
- Registers:
  - `pc` (XLEN bits).
  - `inflight`, $clog2(MAX_INFLIGHT+1) bits.
  - `state`.
  - `invalidate` (registered).
- BOOT:
  - Entered on reset.
  - Moves to RUN after one cycle with reset deasserted.
- RUN:
  - `next_pc_tvalid` = (`inflight` < MAX_INFLIGHT); `next_pc_tdata` = `pc`.
  - On a next-PC handshake: `pc` <= `pc` + 4, modulo 2^XLEN (wraps to 0).
- `inflight` accounting:
  - +1 on a next-PC handshake, −1 on a current-PC handshake.
  - Both in the same cycle: no change.
  - Decrement at 0 saturates at 0. This is a protocol error; flag it with an assertion.
- `current_pc_tready` = 1 in RUN and FLUSH, 0 in BOOT. `current_pc_tdata` is only used by assertions: in RUN it must equal the oldest issued PC.
- `redirect_valid` sampled in any state other than BOOT:
  - `pc` <= {`redirect_pc`[XLEN-1:2], 2'b00}.
  - `invalidate` <= 1 next cycle.
  - `state` <= FLUSH.
  - Redirect has priority over the sequential increment in the same cycle.
- A next-PC handshake in the same cycle as a redirect still counts into `inflight`; that beat is stale.
- FLUSH:
  - `next_pc_tvalid` = 0.
  - Current-PC beats are accepted and discarded, decrementing `inflight`.
  - Leaves for RUN in the cycle after `inflight` reaches 0 with no redirect sampled that cycle.
  - A redirect arriving in FLUSH overwrites `pc`, re-pulses `invalidate` and stays in FLUSH.
- Withdrawing `next_pc_tvalid` without a handshake is permitted only on a redirect. `invalidate` informs the IFU that the pending beat is dropped.
- Redirect in BOOT is ignored.

## Timing

- While `rst` is low, at the next edge:
  - `next_pc_tvalid` = 0, `next_pc_tdata` = RESET_VECTOR.
  - `current_pc_tready` = 0, `invalidate` = 0.
  - `inflight` = 0, `state` = BOOT.
- Reset mid-operation discards all in-flight state. No `invalidate` is emitted by reset itself.
- First `next_pc_tvalid` = 1 occurs 2 cycles after the first edge with `rst` high: cycle 1 is BOOT, cycle 2 is RUN.
- Back-to-back issue: one PC per cycle while `next_pc_tready` = 1 and `inflight` < MAX_INFLIGHT.
- If a current-PC return frees a slot in cycle N, issue resumes in cycle N+1. `next_pc_tvalid` is derived from registered `inflight` only, with no combinational path from `current_pc_tvalid`.
- `next_pc_tdata` is stable while `next_pc_tvalid` is high and `next_pc_tready` is low, except on a redirect.
- Redirect sampled in cycle N:
  - `invalidate` is high in cycle N+1 only, unless another redirect follows.
  - With `inflight` = 0 at N+1, the redirect target is presented in cycle N+2.
- Consecutive redirects: `invalidate` is high for each cycle following a sampled redirect; the last target wins.
- No combinational path from any input to `next_pc_tvalid` or `invalidate`.

## Structure

- `offnariscv_pkg` gets:
  - `pcgen_state_e` (BOOT, RUN, FLUSH).
  - `PCGEN_RESET_VECTOR` as the default for RESET_VECTOR.
- Top level uses `axis_if` modports for next-PC and current-PC.
- One natural sub-module: `pcgen_inflight_ctr`, a saturating up/down counter with a limit compare.
- Test wrapper `pcgen_wrap` flattens the interfaces to the port list above for the cocotb bench.

## Test plan

- Release reset, `next_pc_tready` = 1, current-PC echoed one cycle after issue → PCs 0x80000000, 0x80000004, 0x80000008 issued one per cycle from cycle 2; `invalidate` never asserts.
- `next_pc_tready` = 1, no current-PC returns → exactly 2 beats issued, then `next_pc_tvalid` low. One return → third beat (0x80000008) appears on the next cycle.
- `next_pc_tready` = 0 for 5 cycles → `next_pc_tdata` holds 0x80000000 and `next_pc_tvalid` stays high.
- Redirect to 0x80001003 with `inflight` = 2 → `invalidate` pulses one cycle; no issue until 2 returns are discarded; then 0x80001000, then 0x80001004.
- Redirects in 2 consecutive cycles (0x100, then 0x200) → `invalidate` high 2 cycles; the first issued PC is 0x200.
- Start at `pc` = 0xFFFFFFFC via redirect → issues 0xFFFFFFFC, then 0x00000000. Assert `rst` low mid-FLUSH → BOOT state, and the first issue after release is RESET_VECTOR.
